// File: rtl/rx_slot_sched_pkg.sv
// Shared widths, default sizing and interrupt FSM encoding for the RX slot scheduler.
package rx_slot_sched_pkg;

  localparam int ETH_LEN_W = 12;
  localparam int ETH_TS_W  = 32;
  localparam int META_W    = ETH_LEN_W + ETH_TS_W;

  localparam int DEF_NSLOTS      = 4;
  localparam int DEF_IDX_W       = 2;
  localparam int DEF_IRQ_THRESH  = 2;
  localparam int DEF_IRQ_HOLDOFF = 1250;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_HOLD = 2'd1,
    IRQ_FIRE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/rx_slot_sched_irq_mod.sv
// Interrupt moderation: fires on a pending-count threshold or once the oldest
// pending frame has waited the holdoff time; cleared by ack, drain or disable.
module rx_irq_mod
  import rx_slot_sched_pkg::*;
#(
  parameter int IDX_W       = DEF_IDX_W,
  parameter int IRQ_THRESH  = DEF_IRQ_THRESH,
  parameter int IRQ_HOLDOFF = DEF_IRQ_HOLDOFF
) (
  input  logic             clk_125,
  input  logic             rstn,
  input  logic [IDX_W:0]   i_count,
  input  logic             i_irq_en,
  input  logic             i_irq_ack,
  output logic             o_irq
);

  localparam int TIMER_W = $clog2(IRQ_HOLDOFF + 1);

  irq_state_e          r_state;
  irq_state_e          w_state_next;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_irq;
  logic                w_nonzero;
  logic                w_at_thresh;
  logic                w_expired;

  assign w_nonzero   = (i_count != '0);
  assign w_at_thresh = (i_count >= (IDX_W+1)'(IRQ_THRESH));
  assign w_expired   = (r_timer == TIMER_W'(IRQ_HOLDOFF - 1));

  // Next-state decode; disabling or draining always wins over firing.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IRQ_IDLE: begin
        if (i_irq_en && w_at_thresh)    w_state_next = IRQ_FIRE;
        else if (i_irq_en && w_nonzero) w_state_next = IRQ_HOLD;
      end
      IRQ_HOLD: begin
        if (!i_irq_en || !w_nonzero)      w_state_next = IRQ_IDLE;
        else if (w_expired || w_at_thresh) w_state_next = IRQ_FIRE;
      end
      IRQ_FIRE: begin
        if (i_irq_ack || !w_nonzero || !i_irq_en) w_state_next = IRQ_IDLE;
      end
      default: w_state_next = IRQ_IDLE;
    endcase
  end

  // State, holdoff timer and registered irq level.
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      r_state <= IRQ_IDLE;
      r_timer <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_irq   <= (w_state_next == IRQ_FIRE);
      if (w_state_next == IRQ_IDLE)  r_timer <= '0;
      else if (r_state == IRQ_HOLD)  r_timer <= r_timer + TIMER_W'(1);
    end
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/rx_slot_sched.sv
// RX slot ring scheduler: write/read pointers over NSLOTS frame slots shared by
// the Ethernet writer and the host reader, with per-slot length/timestamp store.
module rx_slot_sched
  import rx_slot_sched_pkg::*;
#(
  parameter int NSLOTS      = DEF_NSLOTS,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int IRQ_THRESH  = DEF_IRQ_THRESH,
  parameter int IRQ_HOLDOFF = DEF_IRQ_HOLDOFF
) (
  input  logic                 clk_125,
  input  logic                 rstn,
  input  logic                 i_rx_done,
  input  logic [ETH_LEN_W-1:0] i_rx_frame_len,
  input  logic [ETH_TS_W-1:0]  i_rx_timestamp,
  output logic [IDX_W-1:0]     o_eth_slot_idx,
  output logic                 o_eth_slot_free,
  input  logic                 i_host_release,
  input  logic                 i_irq_ack,
  input  logic                 i_irq_en,
  output logic [IDX_W-1:0]     o_host_slot_idx,
  output logic [IDX_W:0]       o_host_pending,
  output logic [ETH_LEN_W-1:0] o_host_len,
  output logic [ETH_TS_W-1:0]  o_host_ts,
  output logic [15:0]          o_drop_cnt,
  output logic                 o_rel_err,
  output logic                 o_irq
);

  logic [IDX_W-1:0]     r_wr_ptr;
  logic [IDX_W-1:0]     r_rd_ptr;
  logic [IDX_W:0]       r_count;
  logic [15:0]          r_drop_cnt;
  logic                 r_rel_err;
  logic [ETH_LEN_W-1:0] r_host_len;
  logic [ETH_TS_W-1:0]  r_host_ts;
  logic [META_W-1:0]    r_meta [NSLOTS];

  logic                 w_full;
  logic                 w_empty;
  logic                 w_rel_ok;
  logic                 w_accept;
  logic                 w_drop;
  logic [IDX_W-1:0]     w_rd_ptr_next;
  logic [META_W-1:0]    w_meta_rd;

  // A release on a full ring frees a slot first, so a same-cycle frame is kept.
  assign w_full        = (r_count == (IDX_W+1)'(NSLOTS));
  assign w_empty       = (r_count == '0);
  assign w_rel_ok      = i_host_release && !w_empty;
  assign w_accept      = i_rx_done && (!w_full || w_rel_ok);
  assign w_drop        = i_rx_done && !w_accept;
  assign w_rd_ptr_next = w_rel_ok ? (r_rd_ptr + IDX_W'(1)) : r_rd_ptr;
  assign w_meta_rd     = r_meta[w_rd_ptr_next];

  // Metadata store: written on accepted frames only, never reset.
  always_ff @(posedge clk_125) begin
    if (w_accept) r_meta[r_wr_ptr] <= {i_rx_frame_len, i_rx_timestamp};
  end

  // Ring pointers, occupancy, error/drop accounting and host-facing metadata.
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_rel_err  <= 1'b0;
      r_host_len <= '0;
      r_host_ts  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + IDX_W'(1);
      r_rd_ptr <= w_rd_ptr_next;
      if (w_accept && !w_rel_ok)      r_count <= r_count + (IDX_W+1)'(1);
      else if (!w_accept && w_rel_ok) r_count <= r_count - (IDX_W+1)'(1);
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (i_host_release && w_empty) r_rel_err <= 1'b1;
      r_host_len <= w_meta_rd[META_W-1:ETH_TS_W];
      r_host_ts  <= w_meta_rd[ETH_TS_W-1:0];
    end
  end

  rx_irq_mod #(
    .IDX_W       (IDX_W),
    .IRQ_THRESH  (IRQ_THRESH),
    .IRQ_HOLDOFF (IRQ_HOLDOFF)
  ) u_irq (
    .clk_125   (clk_125),
    .rstn      (rstn),
    .i_count   (r_count),
    .i_irq_en  (i_irq_en),
    .i_irq_ack (i_irq_ack),
    .o_irq     (o_irq)
  );

  assign o_eth_slot_idx  = r_wr_ptr;
  assign o_eth_slot_free = !w_full;
  assign o_host_slot_idx = r_rd_ptr;
  assign o_host_pending  = r_count;
  assign o_host_len      = r_host_len;
  assign o_host_ts       = r_host_ts;
  assign o_drop_cnt      = r_drop_cnt;
  assign o_rel_err       = r_rel_err;

endmodule

// File: tb/tb_rx_slot_sched.sv
// Bench for rx_slot_sched: scenario tasks backed by a FIFO scoreboard of frames.
module tb_rx_slot_sched;

  localparam int NSLOTS      = 4;
  localparam int IDX_W       = 2;
  localparam int IRQ_THRESH  = 2;
  localparam int IRQ_HOLDOFF = 1250;

  logic             clk_125 = 1'b0;
  logic             rstn    = 1'b0;
  logic             rx_done = 1'b0;
  logic [11:0]      rx_frame_len = '0;
  logic [31:0]      rx_timestamp = '0;
  logic             host_release = 1'b0;
  logic             irq_ack = 1'b0;
  logic             irq_en  = 1'b0;
  logic [IDX_W-1:0] eth_slot_idx;
  logic             eth_slot_free;
  logic [IDX_W-1:0] host_slot_idx;
  logic [IDX_W:0]   host_pending;
  logic [11:0]      host_len;
  logic [31:0]      host_ts;
  logic [15:0]      drop_cnt;
  logic             rel_err;
  logic             irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: frames the ring should hold, oldest first, plus model state.
  logic [43:0] sb[$];
  int          m_wr = 0;
  int          m_rd = 0;
  logic [15:0] m_drop = '0;
  logic        m_rel_err = 1'b0;
  int          rd_wraps = 0;

  rx_slot_sched #(
    .NSLOTS      (NSLOTS),
    .IDX_W       (IDX_W),
    .IRQ_THRESH  (IRQ_THRESH),
    .IRQ_HOLDOFF (IRQ_HOLDOFF)
  ) dut (
    .clk_125         (clk_125),
    .rstn            (rstn),
    .i_rx_done       (rx_done),
    .i_rx_frame_len  (rx_frame_len),
    .i_rx_timestamp  (rx_timestamp),
    .o_eth_slot_idx  (eth_slot_idx),
    .o_eth_slot_free (eth_slot_free),
    .i_host_release  (host_release),
    .i_irq_ack       (irq_ack),
    .i_irq_en        (irq_en),
    .o_host_slot_idx (host_slot_idx),
    .o_host_pending  (host_pending),
    .o_host_len      (host_len),
    .o_host_ts       (host_ts),
    .o_drop_cnt      (drop_cnt),
    .o_rel_err       (rel_err),
    .o_irq           (irq)
  );

  always #4 clk_125 = ~clk_125;

  initial begin
    repeat (60000) @(posedge clk_125);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    sb.delete();
    m_wr = 0;
    m_rd = 0;
    m_drop = '0;
    m_rel_err = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    rx_done = 1'b0;
    host_release = 1'b0;
    irq_ack = 1'b0;
    repeat (2) @(posedge clk_125);
    #1 rstn = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus; the model follows the ring rules (release first).
  task automatic step(input bit done, input logic [11:0] len, input logic [31:0] ts,
                      input bit rel, input bit ack);
    if (rel) begin
      if (sb.size() > 0) begin
        void'(sb.pop_front());
        m_rd = (m_rd + 1) % NSLOTS;
        if (m_rd == 0) rd_wraps++;
      end else begin
        m_rel_err = 1'b1;
      end
    end
    if (done) begin
      if (sb.size() < NSLOTS) begin
        sb.push_back({len, ts});
        m_wr = (m_wr + 1) % NSLOTS;
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end
    rx_done = done;
    rx_frame_len = len;
    rx_timestamp = ts;
    host_release = rel;
    irq_ack = ack;
    @(posedge clk_125);
    #1;
    rx_done = 1'b0;
    host_release = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 12'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    n_cmp += 8;
    if (eth_slot_free !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_free: got %0h expected 1", eth_slot_free); end
    if (eth_slot_idx !== '0) begin n_bad++; $display("[TB] FAIL rst_eth_idx: got %0h expected 0", eth_slot_idx); end
    if (host_slot_idx !== '0) begin n_bad++; $display("[TB] FAIL rst_host_idx: got %0h expected 0", host_slot_idx); end
    if (host_pending !== '0) begin n_bad++; $display("[TB] FAIL rst_pending: got %0h expected 0", host_pending); end
    if (drop_cnt !== '0) begin n_bad++; $display("[TB] FAIL rst_drop: got %0h expected 0", drop_cnt); end
    if (rel_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_rel_err: got %0h expected 0", rel_err); end
    if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_irq: got %0h expected 0", irq); end
    if ({host_len, host_ts} !== 44'd0) begin n_bad++; $display("[TB] FAIL rst_meta: got %0h expected 0", {host_len, host_ts}); end
  endtask

  task automatic test_single_frame();
    $display("[TB] test_single_frame");
    do_reset();
    step(1'b1, 12'd64, 32'h1234, 1'b0, 1'b0);
    idle();
    n_cmp += 4;
    if (host_pending !== 3'd1) begin n_bad++; $display("[TB] FAIL single_pending: got %0d expected 1", host_pending); end
    if (host_len !== sb[0][43:32]) begin n_bad++; $display("[TB] FAIL single_len: got %0d expected %0d", host_len, sb[0][43:32]); end
    if (host_ts !== 32'h1234) begin n_bad++; $display("[TB] FAIL single_ts: got %0h expected 1234", host_ts); end
    if (eth_slot_idx !== 2'd1) begin n_bad++; $display("[TB] FAIL single_eth_idx: got %0d expected 1", eth_slot_idx); end
  endtask

  task automatic test_full_drop();
    $display("[TB] test_full_drop");
    do_reset();
    for (int i = 0; i < NSLOTS; i++) step(1'b1, 12'(100 + i), 32'(i * 7), 1'b0, 1'b0);
    n_cmp += 2;
    if (eth_slot_free !== 1'b0) begin n_bad++; $display("[TB] FAIL full_free: got %0h expected 0", eth_slot_free); end
    if (host_pending !== 3'd4) begin n_bad++; $display("[TB] FAIL full_pending: got %0d expected 4", host_pending); end
    step(1'b1, 12'd999, 32'hDEAD, 1'b0, 1'b0);
    n_cmp += 3;
    if (drop_cnt !== m_drop) begin n_bad++; $display("[TB] FAIL drop_cnt: got %0d expected %0d", drop_cnt, m_drop); end
    if (eth_slot_idx !== 2'd0) begin n_bad++; $display("[TB] FAIL drop_wr_ptr: got %0d expected 0", eth_slot_idx); end
    if (host_pending !== 3'd4) begin n_bad++; $display("[TB] FAIL drop_pending: got %0d expected 4", host_pending); end
  endtask

  // Continues from the full ring left by test_full_drop.
  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    step(1'b1, 12'h555, 32'hCAFE, 1'b1, 1'b0);
    n_cmp += 4;
    if (host_pending !== 3'd4) begin n_bad++; $display("[TB] FAIL b2b_pending: got %0d expected 4", host_pending); end
    if (drop_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL b2b_drop: got %0d expected 1", drop_cnt); end
    if (host_slot_idx !== 2'd1) begin n_bad++; $display("[TB] FAIL b2b_rd_ptr: got %0d expected 1", host_slot_idx); end
    if (eth_slot_idx !== 2'd1) begin n_bad++; $display("[TB] FAIL b2b_wr_ptr: got %0d expected 1", eth_slot_idx); end
    idle();
    n_cmp += 1;
    if (host_len !== 12'd101) begin n_bad++; $display("[TB] FAIL b2b_len: got %0d expected 101", host_len); end
  endtask

  task automatic test_rel_err();
    $display("[TB] test_rel_err");
    do_reset();
    step(1'b0, 12'd0, 32'd0, 1'b1, 1'b0);
    idle();
    n_cmp += 2;
    if (rel_err !== 1'b1) begin n_bad++; $display("[TB] FAIL rel_err: got %0h expected 1", rel_err); end
    if (host_pending !== 3'd0) begin n_bad++; $display("[TB] FAIL rel_pending: got %0d expected 0", host_pending); end
  endtask

  task automatic test_irq();
    int first;
    $display("[TB] test_irq");
    do_reset();
    irq_en = 1'b1;
    step(1'b1, 12'd60, 32'h1, 1'b0, 1'b0);
    first = -1;
    for (int k = 1; k <= IRQ_HOLDOFF + 10; k++) begin
      idle();
      if (irq === 1'b1) begin
        first = k;
        break;
      end
    end
    n_cmp += 1;
    if (first != IRQ_HOLDOFF + 1) begin n_bad++; $display("[TB] FAIL irq_holdoff: got %0d expected %0d", first, IRQ_HOLDOFF + 1); end
    step(1'b0, 12'd0, 32'd0, 1'b0, 1'b1);
    n_cmp += 1;
    if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL irq_ack: got %0h expected 0", irq); end

    do_reset();
    step(1'b1, 12'd60, 32'h2, 1'b0, 1'b0);
    repeat (5) idle();
    step(1'b1, 12'd61, 32'h3, 1'b0, 1'b0);
    n_cmp += 1;
    if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL irq_thresh_early: got %0h expected 0", irq); end
    idle();
    n_cmp += 1;
    if (irq !== 1'b1) begin n_bad++; $display("[TB] FAIL irq_thresh: got %0h expected 1", irq); end
    irq_en = 1'b0;
  endtask

  task automatic test_random_wrap();
    int iter;
    bit done, rel;
    $display("[TB] test_random_wrap");
    do_reset();
    rd_wraps = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 12'($urandom), $urandom, 1'b0, 1'b0);
    iter = 0;
    while (rd_wraps < 10 && iter < 2000) begin
      done = 1'($urandom_range(0, 1));
      rel  = 1'($urandom_range(0, 1));
      step(done, 12'($urandom), $urandom, rel, 1'b0);
      idle();
      n_cmp += 6;
      if (host_pending !== 3'(sb.size())) begin n_bad++; $display("[TB] FAIL rnd_pending: got %0d expected %0d", host_pending, sb.size()); end
      if (eth_slot_idx !== 2'(m_wr)) begin n_bad++; $display("[TB] FAIL rnd_wr_ptr: got %0d expected %0d", eth_slot_idx, m_wr); end
      if (host_slot_idx !== 2'(m_rd)) begin n_bad++; $display("[TB] FAIL rnd_rd_ptr: got %0d expected %0d", host_slot_idx, m_rd); end
      if (eth_slot_free !== (sb.size() != NSLOTS)) begin n_bad++; $display("[TB] FAIL rnd_free: got %0h expected %0h", eth_slot_free, sb.size() != NSLOTS); end
      if (drop_cnt !== m_drop) begin n_bad++; $display("[TB] FAIL rnd_drop: got %0d expected %0d", drop_cnt, m_drop); end
      if (rel_err !== m_rel_err) begin n_bad++; $display("[TB] FAIL rnd_rel_err: got %0h expected %0h", rel_err, m_rel_err); end
      if (sb.size() > 0) begin
        n_cmp += 1;
        if ({host_len, host_ts} !== sb[0]) begin n_bad++; $display("[TB] FAIL rnd_meta: got %0h expected %0h", {host_len, host_ts}, sb[0]); end
      end
      iter++;
    end
    n_cmp += 1;
    if (rd_wraps < 10) begin n_bad++; $display("[TB] FAIL rnd_wraps: got %0d expected 10", rd_wraps); end
  endtask

  task automatic test_reset_mid_burst();
    $display("[TB] test_reset_mid_burst");
    do_reset();
    irq_en = 1'b1;
    step(1'b0, 12'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < NSLOTS + 1; i++) step(1'b1, 12'(200 + i), 32'(i + 50), 1'b0, 1'b0);
    idle();
    n_cmp += 1;
    if (irq !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_irq_pre: got %0h expected 1", irq); end
    rstn = 1'b0;
    #2;
    n_cmp += 8;
    if (eth_slot_free !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_free: got %0h expected 1", eth_slot_free); end
    if (eth_slot_idx !== '0) begin n_bad++; $display("[TB] FAIL mid_eth_idx: got %0h expected 0", eth_slot_idx); end
    if (host_slot_idx !== '0) begin n_bad++; $display("[TB] FAIL mid_host_idx: got %0h expected 0", host_slot_idx); end
    if (host_pending !== '0) begin n_bad++; $display("[TB] FAIL mid_pending: got %0h expected 0", host_pending); end
    if (drop_cnt !== '0) begin n_bad++; $display("[TB] FAIL mid_drop: got %0h expected 0", drop_cnt); end
    if (rel_err !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_rel_err: got %0h expected 0", rel_err); end
    if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_irq: got %0h expected 0", irq); end
    if ({host_len, host_ts} !== 44'd0) begin n_bad++; $display("[TB] FAIL mid_meta: got %0h expected 0", {host_len, host_ts}); end
    irq_en = 1'b0;
    @(posedge clk_125);
    #1 rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_full_drop();
    test_back_to_back();
    test_rel_err();
    test_irq();
    test_random_wrap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
